// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcodes and arbiter state encoding shared by the ALU arbiter slice
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLL  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_PASS = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker: first request at or above ptr, with wrap
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any_gnt
);

  localparam logic [ID_W:0] N_W = (ID_W+1)'(N);

  logic [ID_W:0]   pos;
  logic [ID_W-1:0] idx;

  // One extra bit on pos lets ptr+k exceed N-1 before the single wrap subtraction.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    any_gnt = 1'b0;
    pos     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (ID_W+1)'(k);
      if (pos >= N_W) pos = pos - N_W;
      idx = pos[ID_W-1:0];
      if (!any_gnt && req[idx]) begin
        any_gnt     = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_id      = idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one combinational ALU among NUM_REQ requesters
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_in1,
  input  logic [NUM_REQ*WIDTH-1:0] req_in2,
  input  logic [NUM_REQ*3-1:0]     req_ctrl,
  output logic [WIDTH-1:0]         alu_in1,
  output logic [WIDTH-1:0]         alu_in2,
  output logic [2:0]               alu_control,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic                     alu_zero,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_zero
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  arb_state_t         state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    op_id;
  logic [WIDTH-1:0]   op_in1;
  logic [WIDTH-1:0]   op_in2;
  logic [2:0]         op_ctrl;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               any_gnt;

  logic [WIDTH-1:0]   in1_arr  [NUM_REQ];
  logic [WIDTH-1:0]   in2_arr  [NUM_REQ];
  logic [2:0]         ctrl_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign in1_arr[g]  = req_in1[g*WIDTH +: WIDTH];
    assign in2_arr[g]  = req_in2[g*WIDTH +: WIDTH];
    assign ctrl_arr[g] = req_ctrl[g*3 +: 3];
  end

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .any_gnt (any_gnt)
  );

  // rst_n gating keeps req_ready low while reset is held even with requests pending.
  assign req_ready   = (state == IDLE && rst_n) ? gnt : '0;

  assign alu_in1     = op_in1;
  assign alu_in2     = op_in2;
  assign alu_control = op_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      op_id     <= '0;
      op_in1    <= '0;
      op_in2    <= '0;
      op_ctrl   <= ALU_ADD;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // In IDLE req_ready equals the grant, so any_gnt means the handshake completes.
          if (any_gnt) begin
            op_in1  <= in1_arr[gnt_id];
            op_in2  <= in2_arr[gnt_id];
            op_ctrl <= ctrl_arr[gnt_id];
            op_id   <= gnt_id;
            ptr     <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_out;
          rsp_zero  <= alu_zero;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
